uart_tx_frame_ctrl: RTL and testbench

//   Parametrised UART transmit frame engine: accepts a parallel word and serialises it as

---
 rtl/uart_tx_frame_ctrl.sv | 162 ++++++++++++++++
 tb/tb_uart_tx_frame_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame_ctrl.sv
// UART transmit frame engine: start + DATA_WIDTH data bits (LSB first) + optional parity + 1/2 stop bits.
// Optional break generation is compiled in with `define UART_TX_BREAK_EN.
module uart_tx_frame_ctrl #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int BREAK_BITS   = 12
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
`ifdef UART_TX_BREAK_EN
  input  logic                  BREAK_REQ,
`endif
  output logic                  TX_OUT,
  output logic                  BUSY,
  output logic                  DONE
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam int IDX_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_START    = 3'd1;
  localparam logic [2:0] S_DATA     = 3'd2;
  localparam logic [2:0] S_PARITY   = 3'd3;
  localparam logic [2:0] S_STOP1    = 3'd4;
  localparam logic [2:0] S_STOP2    = 3'd5;
`ifdef UART_TX_BREAK_EN
  localparam logic [2:0] S_BREAK    = 3'd6;
  localparam logic [2:0] S_BRK_STOP = 3'd7;
  localparam int BRK_W = $clog2(BREAK_BITS + 1);
  localparam logic [BRK_W-1:0] BRK_LAST = BRK_W'(BREAK_BITS - 1);
  logic [BRK_W-1:0] brk_cnt;
`endif

  logic [2:0]            state;
  logic [CNT_W-1:0]      clk_cnt;
  logic [IDX_W-1:0]      bit_idx;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  par_en_q;
  logic                  stop2_q;
  logic                  par_q;
  logic                  bit_end;

  assign bit_end = (clk_cnt == CNT_LAST);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= S_IDLE;
      clk_cnt  <= '0;
      bit_idx  <= '0;
      data_q   <= '0;
      par_en_q <= 1'b0;
      stop2_q  <= 1'b0;
      par_q    <= 1'b0;
      TX_OUT   <= 1'b1;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
`ifdef UART_TX_BREAK_EN
      brk_cnt  <= '0;
`endif
    end else begin
      DONE <= 1'b0;
      if (state == S_IDLE) begin
        clk_cnt <= '0;
        bit_idx <= '0;
        TX_OUT  <= 1'b1;
`ifdef UART_TX_BREAK_EN
        if (BREAK_REQ) begin
          state   <= S_BREAK;
          brk_cnt <= '0;
          TX_OUT  <= 1'b0;
          BUSY    <= 1'b1;
        end else
`endif
        if (DATA_VALID) begin
          data_q   <= P_DATA;
          par_en_q <= PAR_EN;
          stop2_q  <= STOP2;
          par_q    <= PAR_TYP ? ~^P_DATA : ^P_DATA;
          state    <= S_START;
          TX_OUT   <= 1'b0;
          BUSY     <= 1'b1;
        end
      end else if (!bit_end) begin
        clk_cnt <= clk_cnt + 1'b1;
      end else begin
        clk_cnt <= '0;
        // Data word is shifted out of its latch, so the next bit is always data_q[0].
        case (state)
          S_START: begin
            state  <= S_DATA;
            TX_OUT <= data_q[0];
            data_q <= data_q >> 1;
          end
          S_DATA: begin
            if (bit_idx == IDX_LAST) begin
              bit_idx <= '0;
              if (par_en_q) begin
                state  <= S_PARITY;
                TX_OUT <= par_q;
              end else begin
                state  <= S_STOP1;
                TX_OUT <= 1'b1;
              end
            end else begin
              bit_idx <= bit_idx + 1'b1;
              TX_OUT  <= data_q[0];
              data_q  <= data_q >> 1;
            end
          end
          S_PARITY: begin
            state  <= S_STOP1;
            TX_OUT <= 1'b1;
          end
          S_STOP1: begin
            if (stop2_q) begin
              state <= S_STOP2;
            end else begin
              state <= S_IDLE;
              BUSY  <= 1'b0;
              DONE  <= 1'b1;
            end
          end
          S_STOP2: begin
            state <= S_IDLE;
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
          end
`ifdef UART_TX_BREAK_EN
          // Break holds low for at least BREAK_BITS bit times, then whole bits while requested.
          S_BREAK: begin
            if (brk_cnt != BRK_LAST) begin
              brk_cnt <= brk_cnt + 1'b1;
            end else if (!BREAK_REQ) begin
              state  <= S_BRK_STOP;
              TX_OUT <= 1'b1;
            end
          end
          S_BRK_STOP: begin
            state  <= S_IDLE;
            BUSY   <= 1'b0;
            TX_OUT <= 1'b1;
          end
`endif
          default: begin
            state  <= S_IDLE;
            BUSY   <= 1'b0;
            TX_OUT <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// Self-checking bench for uart_tx_frame_ctrl (DW=8, CPB=4): table vectors, random frames
// against a bit-list reference model, and hand-written reset/back-to-back/break sequences.
module tb_uart_tx_frame_ctrl;
  localparam int DW  = 8;
  localparam int CPB = 4;
  localparam int BB  = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] p_data;
  logic          data_valid, par_en, par_typ, stop2;
  logic          break_req;
  logic          tx, busy, done;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  uart_tx_frame_ctrl #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .BREAK_BITS(BB)) dut (
    .CLK(clk), .RST(rst), .P_DATA(p_data), .DATA_VALID(data_valid),
    .PAR_EN(par_en), .PAR_TYP(par_typ), .STOP2(stop2),
`ifdef UART_TX_BREAK_EN
    .BREAK_REQ(break_req),
`endif
    .TX_OUT(tx), .BUSY(busy), .DONE(done)
  );

  typedef struct {
    logic [DW-1:0] d;
    bit pe, pt, s2;
    int len;
    int par;   // -1: no parity bit in frame
  } vec_t;
  vec_t tbl[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference line sequence: one entry per bit time, built from the frame format rules.
  function automatic void build_frame(input logic [DW-1:0] d, input bit pe, input bit pt,
                                      input bit s2, output bit q[$]);
    int ones = 0;
    q = {};
    q.push_back(1'b0);
    for (int i = 0; i < DW; i++) begin
      q.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (pe) q.push_back(bit'(ones % 2) ^ pt);
    q.push_back(1'b1);
    if (s2) q.push_back(1'b1);
  endfunction

  // Called at a negedge with the DUT idle; sends one frame and checks it cycle by cycle.
  task automatic run_frame(input logic [DW-1:0] d, input bit pe, input bit pt, input bit s2,
                           input int exp_len, input int exp_par);
    bit q[$];
    int n;
    logic par_seen;
    build_frame(d, pe, pt, s2, q);
    for (int w = 0; w < 200 && busy; w++) @(negedge clk);
    p_data = d; par_en = pe; par_typ = pt; stop2 = s2; data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    n = 0;
    par_seen = 1'bx;
    while (busy && n < 200) begin
      if (n < q.size() * CPB) check("tx_bit", 32'(tx), 32'(q[n / CPB]));
      check("done_low_busy", 32'(done), 0);
      if (pe && (n / CPB) == DW + 1) par_seen = tx;
      n++;
      @(negedge clk);
    end
    check("busy_len", n, exp_len);
    check("done_pulse", 32'(done), 1);
    check("tx_idle_after", 32'(tx), 1);
    if (exp_par >= 0) check("parity_bit", 32'(par_seen), 32'(exp_par));
    @(negedge clk);
    check("done_one_cycle", 32'(done), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "timeout");
  end

  initial begin
    bit q1[$], q2[$];
    bit bad;
    logic [DW-1:0] rd;
    bit rpe, rpt, rs2;

    tbl[0] = '{8'hA5, 1'b1, 1'b0, 1'b0, 44, 0};
    tbl[1] = '{8'h01, 1'b1, 1'b1, 1'b1, 48, 0};
    tbl[2] = '{8'hFF, 1'b0, 1'b0, 1'b0, 40, -1};
    tbl[3] = '{8'h00, 1'b1, 1'b1, 1'b0, 44, 1};
    tbl[4] = '{8'h7F, 1'b1, 1'b0, 1'b1, 48, 1};
    tbl[5] = '{8'h80, 1'b0, 1'b1, 1'b1, 44, -1};

    rst = 1'b1; data_valid = 1'b0; p_data = '0; par_en = 1'b0; par_typ = 1'b0;
    stop2 = 1'b0; break_req = 1'b0;

    // Reset held 3 cycles, then idle with no request.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_tx", 32'(tx), 1);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
    end
    rst = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad = 1'b1;
    end
    check("idle_after_reset", 32'(bad), 0);

    foreach (tbl[i]) run_frame(tbl[i].d, tbl[i].pe, tbl[i].pt, tbl[i].s2, tbl[i].len, tbl[i].par);

    for (int i = 0; i < 16; i++) begin
      rd = DW'($urandom); rpe = 1'($urandom); rpt = 1'($urandom); rs2 = 1'($urandom);
      build_frame(rd, rpe, rpt, rs2, q1);
      run_frame(rd, rpe, rpt, rs2, q1.size() * CPB, -1);
    end

    // Back-to-back with DATA_VALID held and inputs scrambled while busy.
    build_frame(8'h3C, 1'b0, 1'b0, 1'b0, q1);
    build_frame(8'hC3, 1'b1, 1'b1, 1'b0, q2);
    p_data = 8'h3C; par_en = 1'b0; par_typ = 1'b0; stop2 = 1'b0; data_valid = 1'b1;
    bad = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (tx !== q1[k / CPB] || busy !== 1'b1) bad = 1'b1;
      p_data = DW'($urandom); par_en = 1'($urandom); stop2 = 1'($urandom);
    end
    check("b2b_frame1", 32'(bad), 0);
    @(negedge clk);
    check("b2b_done1", 32'(done), 1);
    check("b2b_idle_gap", 32'(tx), 1);
    p_data = 8'hC3; par_en = 1'b1; par_typ = 1'b1; stop2 = 1'b0;
    bad = 1'b0;
    for (int k = 0; k < 44; k++) begin
      @(negedge clk);
      data_valid = 1'b0;
      if (tx !== q2[k / CPB] || busy !== 1'b1) bad = 1'b1;
    end
    check("b2b_frame2", 32'(bad), 0);
    @(negedge clk);
    check("b2b_done2", 32'(done), 1);
    @(negedge clk);

    // Reset during data bit 3 (bit time 4 of the frame).
    p_data = 8'h5A; par_en = 1'b1; par_typ = 1'b0; stop2 = 1'b1; data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    for (int k = 0; k < 17; k++) @(negedge clk);
    check("pre_rst_tx_bit3", 32'(tx), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_tx", 32'(tx), 1);
    check("midrst_busy", 32'(busy), 0);
    bad = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) bad = 1'b1;
    end
    check("midrst_no_done", 32'(bad), 0);
    run_frame(8'hA5, 1'b1, 1'b0, 1'b0, 44, 0);

`ifdef UART_TX_BREAK_EN
    // Break and data request in the same idle cycle: break wins, data is dropped.
    break_req = 1'b1; data_valid = 1'b1; p_data = 8'hF0;
    @(negedge clk);
    break_req = 1'b0; data_valid = 1'b0;
    bad = 1'b0;
    for (int k = 0; k < BB * CPB + CPB; k++) begin
      if (tx !== ((k < BB * CPB) ? 1'b0 : 1'b1) || busy !== 1'b1 || done !== 1'b0) bad = 1'b1;
      @(negedge clk);
    end
    check("break_wave", 32'(bad), 0);
    check("break_end_busy", 32'(busy), 0);
    bad = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (done !== 1'b0 || tx !== 1'b1) bad = 1'b1;
      @(negedge clk);
    end
    check("break_no_data", 32'(bad), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
